// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - Opcode, funct3, CSR address and mask constants for csr_write_unit
package csr_pkg;

   localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_CSRRW  = 3'b001;
   localparam logic [2:0] F3_CSRRS  = 3'b010;
   localparam logic [2:0] F3_CSRRC  = 3'b011;
   localparam logic [2:0] F3_CSRRWI = 3'b101;
   localparam logic [2:0] F3_CSRRSI = 3'b110;
   localparam logic [2:0] F3_CSRRCI = 3'b111;

   // Low two funct3 bits select the operation for both register and immediate forms
   typedef enum logic [1:0] {
      CSR_OP_NONE = 2'b00,
      CSR_OP_RW   = 2'b01,
      CSR_OP_RS   = 2'b10,
      CSR_OP_RC   = 2'b11
   } csr_op_e;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

   // Only MIE (bit 3) and MPIE (bit 7) of mstatus are stored
   localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;

   // True for the six funct3 codes that are Zicsr instructions
   function automatic logic is_csr_funct3(input logic [2:0] f3);
      logic hit;
      case (f3)
         F3_CSRRW, F3_CSRRS, F3_CSRRC,
         F3_CSRRWI, F3_CSRRSI, F3_CSRRCI: hit = 1'b1;
         default:                         hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// rtl/csr_counter64.sv - 64-bit counter with enable and independent low/high word loads
module csr_counter64 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc_en_i,
   input  logic        lo_we_i,
   input  logic        hi_we_i,
   input  logic [31:0] wdata_i,
   output logic [63:0] count_o
);

   logic [31:0] lo_q, lo_d;
   logic [31:0] hi_q, hi_d;
   logic        carry;

   // Next-state: a low-word load replaces the increment and blocks the carry;
   // a high-word load wins over a carry while the low word keeps counting
   always_comb begin
      lo_d  = lo_q;
      hi_d  = hi_q;
      carry = inc_en_i && (lo_q == 32'hFFFF_FFFF);
      if (lo_we_i) begin
         lo_d = wdata_i;
      end else if (inc_en_i) begin
         lo_d = lo_q + 32'd1;
      end
      if (hi_we_i) begin
         hi_d = wdata_i;
      end else if (!lo_we_i && carry) begin
         hi_d = hi_q + 32'd1;
      end
   end

   // Counter state, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_q <= '0;
         hi_q <= '0;
      end else begin
         lo_q <= lo_d;
         hi_q <= hi_d;
      end
   end

   assign count_o = {hi_q, lo_q};

endmodule

// File: rtl/csr_write_unit.sv
// rtl/csr_write_unit.sv - M-mode CSR state and write path; CSR_INSTRET_EN adds minstret/minstreth
module csr_write_unit
   import csr_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wb_valid,
   input  logic [31:0] instr,
   input  logic [31:0] rs1_data,
   output logic [31:0] csr_rdata,
   output logic        csr_illegal,
   output logic [63:0] cycle_cnt
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [4:0]  rs1_field;
   logic [11:0] addr;
   csr_op_e     csr_op;
   logic        is_csr;
   logic        write_intent;
   logic [31:0] src;
   logic        csr_known;
   logic [31:0] old_val;
   logic [31:0] new_val;
   logic        illegal_now;
   logic        do_write;
   logic        unused_rd;

   logic [31:0] mstatus_q, mstatus_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic        illegal_q;

   assign opcode    = instr[6:0];
   assign funct3    = instr[14:12];
   assign rs1_field = instr[19:15];
   assign addr      = instr[31:20];
   assign csr_op    = csr_op_e'(funct3[1:0]);
   assign unused_rd = ^instr[11:7];

   assign is_csr       = wb_valid && (opcode == OPCODE_SYSTEM) && is_csr_funct3(funct3);
   assign src          = funct3[2] ? {27'b0, rs1_field} : rs1_data;
   assign write_intent = (csr_op == CSR_OP_RW) || (rs1_field != 5'd0);

`ifdef CSR_INSTRET_EN
   logic [63:0] minstret_cnt;
`endif

   // Read decode: pre-write value of the addressed CSR, zero for unknown addresses
   always_comb begin
      csr_known = 1'b1;
      old_val   = '0;
      case (addr)
         CSR_MSTATUS:             old_val = mstatus_q;
         CSR_MTVEC:               old_val = mtvec_q;
         CSR_MSCRATCH:            old_val = mscratch_q;
         CSR_MEPC:                old_val = mepc_q;
         CSR_MCAUSE:              old_val = mcause_q;
         CSR_MCYCLE, CSR_CYCLE:   old_val = cycle_cnt[31:0];
         CSR_MCYCLEH, CSR_CYCLEH: old_val = cycle_cnt[63:32];
`ifdef CSR_INSTRET_EN
         CSR_MINSTRET, CSR_INSTRET:   old_val = minstret_cnt[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: old_val = minstret_cnt[63:32];
`endif
         default:                 csr_known = 1'b0;
      endcase
   end

   assign csr_rdata = old_val;

   // New value from the read-modify-write operation
   always_comb begin
      new_val = old_val;
      case (csr_op)
         CSR_OP_RW: new_val = src;
         CSR_OP_RS: new_val = old_val | src;
         CSR_OP_RC: new_val = old_val & ~src;
         default:   new_val = old_val;
      endcase
   end

   // Unknown CSRs and writes into the read-only space (addr[11:10]=11) fault without side effects
   assign illegal_now = is_csr && (!csr_known || (write_intent && (addr[11:10] == 2'b11)));
   assign do_write    = is_csr && write_intent && !illegal_now;

   // Next-state for the plain machine CSRs, applying per-register masks
   always_comb begin
      mstatus_d  = mstatus_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      if (do_write) begin
         case (addr)
            CSR_MSTATUS:  mstatus_d  = new_val & MSTATUS_WMASK;
            CSR_MTVEC:    mtvec_d    = {new_val[31:2], 2'b00};
            CSR_MSCRATCH: mscratch_d = new_val;
            CSR_MEPC:     mepc_d     = {new_val[31:2], 2'b00};
            CSR_MCAUSE:   mcause_d   = new_val;
            default:      ;
         endcase
      end
   end

   // Machine CSR registers and the one-cycle illegal-access pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstatus_q  <= '0;
         mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         illegal_q  <= 1'b0;
      end else begin
         mstatus_q  <= mstatus_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         illegal_q  <= illegal_now;
      end
   end

   assign csr_illegal = illegal_q;

   // Free-running cycle counter; cycle_cnt is its register output directly
   csr_counter64 u_mcycle (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_en_i (1'b1),
      .lo_we_i  (do_write && (addr == CSR_MCYCLE)),
      .hi_we_i  (do_write && (addr == CSR_MCYCLEH)),
      .wdata_i  (new_val),
      .count_o  (cycle_cnt)
   );

`ifdef CSR_INSTRET_EN
   // Retired-instruction counter, counting every committed WB cycle
   csr_counter64 u_minstret (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc_en_i (wb_valid),
      .lo_we_i  (do_write && (addr == CSR_MINSTRET)),
      .hi_we_i  (do_write && (addr == CSR_MINSTRETH)),
      .wdata_i  (new_val),
      .count_o  (minstret_cnt)
   );
`endif

endmodule

// File: tb/tb_csr_write_unit.sv
// tb/tb_csr_write_unit.sv - Self-checking bench for csr_write_unit against a behavioural CSR model
module tb_csr_write_unit;

   localparam logic [31:0] MTVEC_RST = 32'h8000_0103;
   localparam logic [31:0] NOP       = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_valid = 1'b0;
   logic [31:0] instr = NOP;
   logic [31:0] rs1_data = '0;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic [63:0] cycle_cnt;

   int checks = 0;
   int errors = 0;

   csr_write_unit #(.MTVEC_RESET(MTVEC_RST)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wb_valid    (wb_valid),
      .instr       (instr),
      .rs1_data    (rs1_data),
      .csr_rdata   (csr_rdata),
      .csr_illegal (csr_illegal),
      .cycle_cnt   (cycle_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] csr_i(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r);
      return {a, r, f3, 5'd1, 7'b1110011};
   endfunction

   // ---------------- behavioural model ----------------
   logic [31:0] m_mstatus = 0, m_mtvec = 0, m_mscratch = 0, m_mepc = 0, m_mcause = 0;
   logic [63:0] m_cyc = 0, m_ins = 0;
   logic        m_ill = 0;
   logic [31:0] n_mstatus = 0, n_mtvec = 0, n_mscratch = 0, n_mepc = 0, n_mcause = 0;
   logic [63:0] n_cyc = 0, n_ins = 0;
   logic        n_ill = 0;

   function automatic logic [31:0] mread(input logic [11:0] a, output bit known);
      known = 1'b1;
      case (a)
         12'h300: return m_mstatus;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'hB00, 12'hC00: return m_cyc[31:0];
         12'hB80, 12'hC80: return m_cyc[63:32];
`ifdef CSR_INSTRET_EN
         12'hB02, 12'hC02: return m_ins[31:0];
         12'hB82, 12'hC82: return m_ins[63:32];
`endif
         default: begin
            known = 1'b0;
            return 32'h0;
         end
      endcase
   endfunction

   // Compare DUT outputs to the model mid-cycle, then derive the state after the next edge
   always @(negedge clk) begin
      bit          known, is_csr, we;
      logic [11:0] a;
      logic [2:0]  f3;
      logic [31:0] old, src, nv;
      logic [31:0] t_mstatus, t_mtvec, t_mscratch, t_mepc, t_mcause;
      logic [63:0] t_cyc, t_ins;
      logic        t_ill;

      a  = instr[31:20];
      f3 = instr[14:12];
      is_csr = wb_valid && (instr[6:0] == 7'b1110011) && (f3[1:0] != 2'b00);
      old = mread(a, known);

      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("csr_illegal", {63'd0, csr_illegal}, {63'd0, m_ill});
      if (is_csr) chk("csr_rdata", {32'd0, csr_rdata}, {32'd0, old});

      t_mstatus = m_mstatus; t_mtvec = m_mtvec; t_mscratch = m_mscratch;
      t_mepc = m_mepc; t_mcause = m_mcause;
      t_cyc = m_cyc + 64'd1;
      t_ins = m_ins + (wb_valid ? 64'd1 : 64'd0);
      t_ill = 1'b0;
      if (is_csr) begin
         src = f3[2] ? {27'd0, instr[19:15]} : rs1_data;
         we  = (f3[1:0] == 2'b01) || (instr[19:15] != 5'd0);
         if (f3[1:0] == 2'b01)      nv = src;
         else if (f3[1:0] == 2'b10) nv = old | src;
         else                       nv = old & ~src;
         if (!known || (we && a[11:10] == 2'b11)) begin
            t_ill = 1'b1;
         end else if (we) begin
            case (a)
               12'h300: t_mstatus  = nv & 32'h88;
               12'h305: t_mtvec    = nv & ~32'h3;
               12'h340: t_mscratch = nv;
               12'h341: t_mepc     = nv & ~32'h3;
               12'h342: t_mcause   = nv;
               12'hB00: t_cyc      = {m_cyc[63:32], nv};
               12'hB80: t_cyc      = {nv, m_cyc[31:0] + 32'd1};
               12'hB02: t_ins      = {m_ins[63:32], nv};
               12'hB82: t_ins      = {nv, m_ins[31:0] + 32'd1};
               default: ;
            endcase
         end
      end
      n_mstatus <= t_mstatus; n_mtvec <= t_mtvec; n_mscratch <= t_mscratch;
      n_mepc <= t_mepc; n_mcause <= t_mcause;
      n_cyc <= t_cyc; n_ins <= t_ins; n_ill <= t_ill;
   end

   // Model state commits on the clock edge; reset applies immediately
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mstatus <= 0; m_mtvec <= MTVEC_RST & ~32'h3; m_mscratch <= 0;
         m_mepc <= 0; m_mcause <= 0; m_cyc <= 0; m_ins <= 0; m_ill <= 0;
      end else begin
         m_mstatus <= n_mstatus; m_mtvec <= n_mtvec; m_mscratch <= n_mscratch;
         m_mepc <= n_mepc; m_mcause <= n_mcause; m_cyc <= n_cyc; m_ins <= n_ins;
         m_ill <= n_ill;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] d);
      @(posedge clk);
      #1;
      wb_valid = v;
      instr    = ins;
      rs1_data = d;
   endtask

   logic [11:0] addrs [16] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02,
                              12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h7C0, 12'h301, 12'hF14};

   initial begin
      logic [11:0] a;
      logic [2:0]  f3;
      logic [4:0]  r;
      logic [31:0] ins;

      #12 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #2;
      chk("idle_cycle_cnt", cycle_cnt, 64'd10);

      // Reset values of the plain CSRs
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, csr_i(3'b010, addrs[i], 5'd0), 32'h0);
         #1 chk("reset_read", {32'd0, csr_rdata}, (addrs[i] == 12'h305) ? 64'h8000_0100 : 64'h0);
      end

      // mscratch read-modify-write
      drive(1'b1, csr_i(3'b001, 12'h340, 5'd1), 32'hDEAD_BEEF);
      drive(1'b1, csr_i(3'b010, 12'h340, 5'd1), 32'h0000_0010);
      #1 chk("mscratch_old", {32'd0, csr_rdata}, 64'hDEAD_BEEF);
      drive(1'b1, csr_i(3'b010, 12'h340, 5'd0), 32'h0);
      #1 chk("mscratch_rs", {32'd0, csr_rdata}, 64'hDEAD_BEFF);

      // mstatus masking and zimm=0 no-write
      drive(1'b1, csr_i(3'b001, 12'h300, 5'd1), 32'h0000_0088);
      drive(1'b1, csr_i(3'b111, 12'h300, 5'd0), 32'hFFFF_FFFF);
      #1 chk("mstatus_rci0", {32'd0, csr_rdata}, 64'h88);
      drive(1'b1, csr_i(3'b001, 12'h300, 5'd1), 32'hFFFF_FFFF);
      #1 chk("mstatus_rw_old", {32'd0, csr_rdata}, 64'h88);
      drive(1'b1, csr_i(3'b010, 12'h300, 5'd0), 32'h0);
      #1 chk("mstatus_masked", {32'd0, csr_rdata}, 64'h88);

      // mcycle load, wrap and carry; then mcycleh overriding the carry
      drive(1'b1, csr_i(3'b001, 12'hB00, 5'd1), 32'hFFFF_FFFF);
      drive(1'b0, NOP, 32'h0);
      #1 chk("mcycle_load", cycle_cnt, 64'h0000_0000_FFFF_FFFF);
      drive(1'b0, NOP, 32'h0);
      #1 chk("mcycle_carry", cycle_cnt, 64'h0000_0001_0000_0000);
      drive(1'b1, csr_i(3'b001, 12'hB00, 5'd1), 32'hFFFF_FFFF);
      drive(1'b1, csr_i(3'b001, 12'hB80, 5'd1), 32'h5);
      #1 chk("mcycleh_old", {32'd0, csr_rdata}, 64'h1);
      drive(1'b0, NOP, 32'h0);
      #1 chk("mcycleh_over_carry", cycle_cnt, 64'h0000_0005_0000_0000);

      // Illegal write to read-only alias, legal read of it, unknown address
      drive(1'b1, csr_i(3'b001, 12'hC00, 5'd1), 32'h1234);
      drive(1'b0, NOP, 32'h0);
      #1 chk("ro_write_pulse", {63'd0, csr_illegal}, 64'd1);
      drive(1'b0, NOP, 32'h0);
      #1 chk("ro_write_pulse_end", {63'd0, csr_illegal}, 64'd0);
      chk("ro_write_no_effect", cycle_cnt, 64'h0000_0005_0000_0003);
      drive(1'b1, csr_i(3'b010, 12'hC00, 5'd0), 32'hFFFF_FFFF);
      #1 chk("cycle_alias_read", {32'd0, csr_rdata}, 64'd4);
      drive(1'b0, NOP, 32'h0);
      #1 chk("ro_read_no_pulse", {63'd0, csr_illegal}, 64'd0);
      drive(1'b1, csr_i(3'b010, 12'h7C0, 5'd0), 32'h0);
      #1 chk("unknown_rdata", {32'd0, csr_rdata}, 64'd0);
      drive(1'b0, NOP, 32'h0);
      #1 chk("unknown_pulse", {63'd0, csr_illegal}, 64'd1);

      // Asynchronous reset in the middle of a cycle
      drive(1'b1, csr_i(3'b001, 12'h341, 5'd1), 32'h0000_0103);
      drive(1'b1, csr_i(3'b010, 12'h341, 5'd0), 32'h0);
      #1 chk("mepc_value", {32'd0, csr_rdata}, 64'h100);
      #1 rst_n = 1'b0;
      #1 chk("async_cycle_cnt", cycle_cnt, 64'd0);
      chk("async_mepc", {32'd0, csr_rdata}, 64'd0);
      chk("async_illegal", {63'd0, csr_illegal}, 64'd0);
      wb_valid = 1'b0;
      instr    = NOP;
      @(posedge clk);
      #2 rst_n = 1'b1;

      // Retired-instruction counting
      drive(1'b1, NOP, 32'h0);
      drive(1'b1, NOP, 32'h0);
      drive(1'b1, NOP, 32'h0);
      drive(1'b1, csr_i(3'b010, 12'hB02, 5'd0), 32'h0);
`ifdef CSR_INSTRET_EN
      #1 chk("minstret_3", {32'd0, csr_rdata}, 64'd3);
      drive(1'b0, NOP, 32'h0);
      #1 chk("minstret_legal", {63'd0, csr_illegal}, 64'd0);
`else
      #1 chk("minstret_absent_rdata", {32'd0, csr_rdata}, 64'd0);
      drive(1'b0, NOP, 32'h0);
      #1 chk("minstret_absent_pulse", {63'd0, csr_illegal}, 64'd1);
`endif

      // Randomized traffic checked every cycle by the model
      for (int i = 0; i < 1500; i++) begin
         a   = addrs[$urandom_range(0, 15)];
         f3  = 3'($urandom_range(0, 7));
         r   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         ins = csr_i(f3, a, r);
         if ($urandom_range(0, 7) == 0) ins[6:0] = 7'($urandom);
         drive($urandom_range(0, 5) != 0, ins, $urandom);
      end

      drive(1'b0, NOP, 32'h0);
      repeat (3) @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
